// File: rtl/lsu_spu_pcxreq_if.sv
// lsu_spu_pcxreq_if
// Bundles the SPU push path, the PCX request/grant handshake and the
// status/credit signals returned to the SPU.
//   slave  : the LSU receiver (lsu_spu_pcxreq)
//   master : the surrounding SPU + PCX arbiter environment
interface lsu_spu_pcxreq_if;

   // SPU -> LSU push path
   logic         spu_lsu_ldst_vld;
   logic [122:0] spu_lsu_ldst_pckt;

   // PCX arbiter -> LSU grant
   logic         pcx_lsu_grant;

   // LSU -> PCX arbiter request
   logic         lsu_pcx_req;
   logic [3:0]   lsu_pcx_dest;
   logic [122:0] lsu_pcx_pckt;

   // LSU -> SPU credit and status
   logic         lsu_spu_ldst_ack;
   logic         lsu_spu_pcx_full;
   logic         lsu_spu_ovfl_err;
   logic         lsu_spu_pcx_perr;

   modport slave (
      input  spu_lsu_ldst_vld,
      input  spu_lsu_ldst_pckt,
      input  pcx_lsu_grant,
      output lsu_pcx_req,
      output lsu_pcx_dest,
      output lsu_pcx_pckt,
      output lsu_spu_ldst_ack,
      output lsu_spu_pcx_full,
      output lsu_spu_ovfl_err,
      output lsu_spu_pcx_perr
   );

   modport master (
      output spu_lsu_ldst_vld,
      output spu_lsu_ldst_pckt,
      output pcx_lsu_grant,
      input  lsu_pcx_req,
      input  lsu_pcx_dest,
      input  lsu_pcx_pckt,
      input  lsu_spu_ldst_ack,
      input  lsu_spu_pcx_full,
      input  lsu_spu_ovfl_err,
      input  lsu_spu_pcx_perr
   );

endinterface

// File: rtl/lsu_spu_pcxreq.sv
// lsu_spu_pcxreq
// LSU-side receiver for SPU load/store PCX packets. Packets pushed by the
// SPU are queued in a DEPTH-entry FIFO and offered to the PCX arbiter one
// at a time. Every grant pops the head and returns a one-cycle credit pulse
// to the SPU. After each grant the request drops for one cycle to keep the
// arbiter spacing.
//
// Optional feature: define LSU_SPU_PCXREQ_PARITY_EN to store an even-parity
// bit per entry and pulse lsu_spu_pcx_perr when a popped entry's parity no
// longer matches its data. Without the macro, lsu_spu_pcx_perr is tied low.
//
// Reset is synchronous and active-low (reset_l) on rclk.
module lsu_spu_pcxreq #(
   parameter int DEPTH = 2
) (
   input  logic             rclk,
   input  logic             reset_l,
   lsu_spu_pcxreq_if.slave  pcx
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = AW + 1;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_REQ  = 2'd1;
   localparam logic [1:0] ST_GAP  = 2'd2;

   // FIFO storage and bookkeeping
   logic [122:0]  mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q;
   logic [AW-1:0] rd_ptr_q;
   logic [CW-1:0] count_q;
   logic [CW-1:0] count_nxt;

   // Request FSM
   logic [1:0]    state_q;
   logic [1:0]    state_nxt;

   // Registered status/credit outputs
   logic          ack_q;
   logic          ovfl_q;
   logic          perr_q;

   // Per-cycle control
   logic          fifo_full;
   logic          fifo_empty;
   logic          pop;
   logic          push;
   logic          ovfl_set;
   logic          perr_nxt;
   logic [122:0]  head_pckt;

   assign fifo_full  = (count_q == CW'(DEPTH));
   assign fifo_empty = (count_q == '0);
   assign head_pckt  = mem_q[rd_ptr_q];

   // A grant only counts while the request is actually being presented;
   // grants in IDLE or GAP are ignored.
   assign pop      = (state_q == ST_REQ) && pcx.pcx_lsu_grant;

   // A push into a full FIFO still fits when the head leaves in the same
   // cycle; otherwise it is dropped and flagged.
   assign push     = pcx.spu_lsu_ldst_vld && (!fifo_full || pop);
   assign ovfl_set = pcx.spu_lsu_ldst_vld && fifo_full && !pop;

   // Occupancy after this edge; a simultaneous push and pop cancel out
   always_comb begin
      count_nxt = count_q;
      unique case ({push, pop})
         2'b10:   count_nxt = count_q + CW'(1);
         2'b01:   count_nxt = count_q - CW'(1);
         default: count_nxt = count_q;
      endcase
   end

   // Next-state logic; the FSM looks at post-edge occupancy so a push can
   // raise the request in the very next cycle
   always_comb begin
      state_nxt = state_q;
      unique case (state_q)
         ST_IDLE: begin
            if (count_nxt != '0) state_nxt = ST_REQ;
         end
         ST_REQ: begin
            if (pop) state_nxt = ST_GAP;
         end
         ST_GAP: begin
            state_nxt = (count_nxt != '0) ? ST_REQ : ST_IDLE;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   // FIFO data array; contents need no reset because the pointers and count
   // decide what is visible
   always_ff @(posedge rclk) begin
      if (reset_l && push) begin
         mem_q[wr_ptr_q] <= pcx.spu_lsu_ldst_pckt;
      end
   end

   // Pointers, occupancy, FSM state and registered outputs
   always_ff @(posedge rclk) begin
      if (!reset_l) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         state_q  <= ST_IDLE;
         ack_q    <= 1'b0;
         ovfl_q   <= 1'b0;
         perr_q   <= 1'b0;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
         if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
         count_q <= count_nxt;
         state_q <= state_nxt;
         ack_q   <= pop;
         if (ovfl_set) ovfl_q <= 1'b1;
         perr_q  <= perr_nxt;
      end
   end

`ifdef LSU_SPU_PCXREQ_PARITY_EN
   // One even-parity bit per entry, captured alongside the packet
   logic par_q [DEPTH];

   // Parity array written in lockstep with the data array
   always_ff @(posedge rclk) begin
      if (reset_l && push) begin
         par_q[wr_ptr_q] <= ^pcx.spu_lsu_ldst_pckt;
      end
   end

   // Re-check the head entry as it is popped; the packet is forwarded anyway
   always_comb begin
      perr_nxt = 1'b0;
      if (pop) perr_nxt = ((^head_pckt) != par_q[rd_ptr_q]);
   end
`else
   // No parity storage in this build, so no error can ever be raised
   always_comb begin
      perr_nxt = 1'b0;
   end
`endif

   // Head-driven request payload, zeroed whenever nothing is queued
   always_comb begin
      pcx.lsu_pcx_pckt = '0;
      pcx.lsu_pcx_dest = 4'b0000;
      if (!fifo_empty) begin
         pcx.lsu_pcx_pckt = head_pckt;
         pcx.lsu_pcx_dest = 4'b0001 << head_pckt[71:70];
      end
   end

   assign pcx.lsu_pcx_req      = (state_q == ST_REQ);
   assign pcx.lsu_spu_ldst_ack = ack_q;
   assign pcx.lsu_spu_pcx_full = fifo_full;
   assign pcx.lsu_spu_ovfl_err = ovfl_q;
   assign pcx.lsu_spu_pcx_perr = perr_q;

endmodule

// File: tb/tb_lsu_spu_pcxreq.sv
// tb_lsu_spu_pcxreq
// Directed bench for lsu_spu_pcxreq (DEPTH=2). Inputs change 1 time unit
// after each rising edge and outputs are sampled at that same point, so each
// check sees the state produced by the edge just taken.
module tb_lsu_spu_pcxreq;

   logic rclk;
   logic reset_l;
   int   checkCount;
   int   failCount;

   lsu_spu_pcxreq_if bus ();

   lsu_spu_pcxreq #(.DEPTH(2)) dut (
      .rclk    (rclk),
      .reset_l (reset_l),
      .pcx     (bus)
   );

   // Free-running core clock
   initial begin
      rclk = 1'b0;
      forever #5 rclk = ~rclk;
   end

   // Compare one observed value with its expected value and log mismatches
   task automatic checkOutput(input string tag, input logic [122:0] obs,
                              input logic [122:0] exp);
      checkCount++;
      if (obs !== exp) begin
         failCount++;
         $display("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Drive one cycle's inputs, take the edge, settle just after it
   task automatic applyStimulus(input logic vld, input logic [122:0] pkt,
                                input logic gnt);
      bus.spu_lsu_ldst_vld  = vld;
      bus.spu_lsu_ldst_pckt = pkt;
      bus.pcx_lsu_grant     = gnt;
      @(posedge rclk);
      #1;
   endtask

   function automatic logic [122:0] mkPkt(input logic v, input logic [1:0] bank,
                                          input logic [31:0] tag);
      logic [122:0] p;
      p          = '0;
      p[122]     = v;
      p[71:70]   = bank;
      p[31:0]    = tag;
      p[110:100] = tag[10:0];
      return p;
   endfunction

   logic [122:0] pA, pB, pC, pD, pE, pF, pG, pH, pI, pJ, zero;

   initial begin
      checkCount = 0;
      failCount  = 0;
      zero = '0;
      pA = mkPkt(1'b1, 2'b10, 32'hA0A0_0001);
      pB = mkPkt(1'b1, 2'b00, 32'hB0B0_0002);
      pC = mkPkt(1'b1, 2'b01, 32'hC0C0_0003);
      pD = mkPkt(1'b1, 2'b11, 32'hD0D0_0004);
      pE = mkPkt(1'b1, 2'b11, 32'hE0E0_0005);
      pF = mkPkt(1'b1, 2'b00, 32'hF0F0_0006);
      pG = mkPkt(1'b1, 2'b01, 32'h1234_0007);
      pH = mkPkt(1'b1, 2'b10, 32'h5555_0008);
      pI = mkPkt(1'b1, 2'b01, 32'h6666_0009);
      pJ = mkPkt(1'b0, 2'b01, 32'h7777_000A);

      bus.spu_lsu_ldst_vld  = 1'b0;
      bus.spu_lsu_ldst_pckt = '0;
      bus.pcx_lsu_grant     = 1'b0;

      // ---- reset state
      reset_l = 1'b0;
      applyStimulus(1'b0, zero, 1'b0);
      applyStimulus(1'b0, zero, 1'b0);
      checkOutput("rst_req",  bus.lsu_pcx_req,      1'b0);
      checkOutput("rst_ack",  bus.lsu_spu_ldst_ack, 1'b0);
      checkOutput("rst_full", bus.lsu_spu_pcx_full, 1'b0);
      checkOutput("rst_ovfl", bus.lsu_spu_ovfl_err, 1'b0);
      checkOutput("rst_perr", bus.lsu_spu_pcx_perr, 1'b0);
      checkOutput("rst_pckt", bus.lsu_pcx_pckt,     zero);
      checkOutput("rst_dest", bus.lsu_pcx_dest,     4'b0000);
      reset_l = 1'b1;

      // ---- single packet, bank 2, granted on first REQ cycle
      applyStimulus(1'b1, pA, 1'b0);
      checkOutput("t1_req",  bus.lsu_pcx_req,  1'b1);
      checkOutput("t1_pckt", bus.lsu_pcx_pckt, pA);
      checkOutput("t1_dest", bus.lsu_pcx_dest, 4'b0100);
      checkOutput("t1_ack0", bus.lsu_spu_ldst_ack, 1'b0);
      applyStimulus(1'b0, zero, 1'b1);
      checkOutput("t1_gap_req", bus.lsu_pcx_req,      1'b0);
      checkOutput("t1_ack",     bus.lsu_spu_ldst_ack, 1'b1);
      checkOutput("t1_empty",   bus.lsu_pcx_pckt,     zero);
      checkOutput("t1_edest",   bus.lsu_pcx_dest,     4'b0000);
      applyStimulus(1'b0, zero, 1'b0);
      checkOutput("t1_idle_req", bus.lsu_pcx_req,      1'b0);
      checkOutput("t1_ack_end",  bus.lsu_spu_ldst_ack, 1'b0);
      applyStimulus(1'b0, zero, 1'b1);
      checkOutput("t1_idle_gnt_req", bus.lsu_pcx_req,      1'b0);
      checkOutput("t1_idle_gnt_ack", bus.lsu_spu_ldst_ack, 1'b0);

      // ---- fill and overflow
      applyStimulus(1'b1, pB, 1'b0);
      checkOutput("t2_full1", bus.lsu_spu_pcx_full, 1'b0);
      applyStimulus(1'b1, pC, 1'b0);
      checkOutput("t2_full2", bus.lsu_spu_pcx_full, 1'b1);
      checkOutput("t2_head2", bus.lsu_pcx_pckt,     pB);
      checkOutput("t2_ovfl0", bus.lsu_spu_ovfl_err, 1'b0);
      applyStimulus(1'b1, pD, 1'b0);
      checkOutput("t2_ovfl",  bus.lsu_spu_ovfl_err, 1'b1);
      checkOutput("t2_full3", bus.lsu_spu_pcx_full, 1'b1);
      checkOutput("t2_head3", bus.lsu_pcx_pckt,     pB);
      checkOutput("t2_dest3", bus.lsu_pcx_dest,     4'b0001);
      applyStimulus(1'b0, zero, 1'b1);
      checkOutput("t2_pop1_ack",  bus.lsu_spu_ldst_ack, 1'b1);
      checkOutput("t2_pop1_gap",  bus.lsu_pcx_req,      1'b0);
      checkOutput("t2_pop1_head", bus.lsu_pcx_pckt,     pC);
      checkOutput("t2_pop1_full", bus.lsu_spu_pcx_full, 1'b0);
      applyStimulus(1'b0, zero, 1'b1);
      checkOutput("t2_gap_gnt_ack", bus.lsu_spu_ldst_ack, 1'b0);
      checkOutput("t2_req2",        bus.lsu_pcx_req,      1'b1);
      checkOutput("t2_head_c",      bus.lsu_pcx_pckt,     pC);
      checkOutput("t2_dest_c",      bus.lsu_pcx_dest,     4'b0010);
      applyStimulus(1'b0, zero, 1'b1);
      checkOutput("t2_pop2_ack",  bus.lsu_spu_ldst_ack, 1'b1);
      checkOutput("t2_pop2_head", bus.lsu_pcx_pckt,     zero);
      applyStimulus(1'b0, zero, 1'b0);
      checkOutput("t2_idle_req",  bus.lsu_pcx_req,      1'b0);
      checkOutput("t2_ovfl_stk",  bus.lsu_spu_ovfl_err, 1'b1);

      // ---- reset mid-operation with two packets queued
      applyStimulus(1'b1, pH, 1'b0);
      applyStimulus(1'b1, pI, 1'b0);
      checkOutput("t5_req_pre",  bus.lsu_pcx_req,      1'b1);
      checkOutput("t5_full_pre", bus.lsu_spu_pcx_full, 1'b1);
      reset_l = 1'b0;
      applyStimulus(1'b0, zero, 1'b1);
      checkOutput("t5_req",  bus.lsu_pcx_req,      1'b0);
      checkOutput("t5_ack",  bus.lsu_spu_ldst_ack, 1'b0);
      checkOutput("t5_full", bus.lsu_spu_pcx_full, 1'b0);
      checkOutput("t5_ovfl", bus.lsu_spu_ovfl_err, 1'b0);
      checkOutput("t5_pckt", bus.lsu_pcx_pckt,     zero);
      checkOutput("t5_dest", bus.lsu_pcx_dest,     4'b0000);
      reset_l = 1'b1;
      applyStimulus(1'b0, zero, 1'b0);
      checkOutput("t5_post_ack",  bus.lsu_spu_ldst_ack, 1'b0);
      checkOutput("t5_post_req",  bus.lsu_pcx_req,      1'b0);
      checkOutput("t5_post_pckt", bus.lsu_pcx_pckt,     zero);

      // ---- push and pop in the same cycle while full
      applyStimulus(1'b1, pE, 1'b0);
      checkOutput("t3_req",  bus.lsu_pcx_req,  1'b1);
      checkOutput("t3_dest", bus.lsu_pcx_dest, 4'b1000);
      applyStimulus(1'b1, pF, 1'b0);
      checkOutput("t3_full", bus.lsu_spu_pcx_full, 1'b1);
      applyStimulus(1'b1, pG, 1'b1);
      checkOutput("t3_full_keep", bus.lsu_spu_pcx_full, 1'b1);
      checkOutput("t3_no_ovfl",   bus.lsu_spu_ovfl_err, 1'b0);
      checkOutput("t3_ack_e",     bus.lsu_spu_ldst_ack, 1'b1);
      checkOutput("t3_head_f",    bus.lsu_pcx_pckt,     pF);
      applyStimulus(1'b0, zero, 1'b0);
      checkOutput("t3_req_f", bus.lsu_pcx_req, 1'b1);
      applyStimulus(1'b0, zero, 1'b1);
      checkOutput("t3_ack_f",  bus.lsu_spu_ldst_ack, 1'b1);
      checkOutput("t3_head_g", bus.lsu_pcx_pckt,     pG);
      checkOutput("t3_full_0", bus.lsu_spu_pcx_full, 1'b0);
      applyStimulus(1'b0, zero, 1'b0);
      checkOutput("t3_req_g",  bus.lsu_pcx_req,  1'b1);
      checkOutput("t3_dest_g", bus.lsu_pcx_dest, 4'b0010);
      applyStimulus(1'b0, zero, 1'b1);
      checkOutput("t3_ack_g", bus.lsu_spu_ldst_ack, 1'b1);
      checkOutput("t3_empty", bus.lsu_pcx_pckt,     zero);
      applyStimulus(1'b0, zero, 1'b0);
      checkOutput("t3_idle", bus.lsu_pcx_req, 1'b0);

      // ---- grant stall (packet with valid bit clear is still forwarded)
      applyStimulus(1'b1, pJ, 1'b0);
      for (int i = 0; i < 10; i++) begin
         checkOutput("t4_stall_req",  bus.lsu_pcx_req,      1'b1);
         checkOutput("t4_stall_pckt", bus.lsu_pcx_pckt,     pJ);
         checkOutput("t4_stall_ack",  bus.lsu_spu_ldst_ack, 1'b0);
         applyStimulus(1'b0, zero, 1'b0);
      end
      checkOutput("t4_req_last", bus.lsu_pcx_req, 1'b1);
      applyStimulus(1'b0, zero, 1'b1);
      checkOutput("t4_ack",  bus.lsu_spu_ldst_ack, 1'b1);
      checkOutput("t4_perr", bus.lsu_spu_pcx_perr, 1'b0);
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1'b0, zero, 1'b0);
         checkOutput("t4_single_ack", bus.lsu_spu_ldst_ack, 1'b0);
         checkOutput("t4_idle_req",   bus.lsu_pcx_req,      1'b0);
      end

`ifdef LSU_SPU_PCXREQ_PARITY_EN
      // ---- corrupted stored bit is flagged yet still forwarded
      begin
         logic [122:0] corrupt;
         corrupt     = pA;
         corrupt[40] = ~corrupt[40];
         applyStimulus(1'b1, pA, 1'b0);
         dut.mem_q[dut.rd_ptr_q] = corrupt;
         #1;
         checkOutput("t6_fwd",  bus.lsu_pcx_pckt, corrupt);
         applyStimulus(1'b0, zero, 1'b1);
         checkOutput("t6_perr", bus.lsu_spu_pcx_perr, 1'b1);
         checkOutput("t6_ack",  bus.lsu_spu_ldst_ack, 1'b1);
         applyStimulus(1'b0, zero, 1'b0);
         checkOutput("t6_perr_end", bus.lsu_spu_pcx_perr, 1'b0);
      end
`else
      // ---- without parity support the error output never rises
      applyStimulus(1'b1, pA, 1'b0);
      applyStimulus(1'b0, zero, 1'b1);
      checkOutput("t6_ack",     bus.lsu_spu_ldst_ack, 1'b1);
      checkOutput("t6_perr_na", bus.lsu_spu_pcx_perr, 1'b0);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
      $finish;
   end

endmodule
